aes_run_ctrl: RTL

- Synthesizable run controller that launches a set of AES channel engines and collects their per-channel done/pass results.
- Channels are encrypt/decrypt engines at Nk = 4/6/8.
- Parametrised in channel count, launch mode (all-parallel or one-at-a-time) and watchdog timeout.
- Sits between the top-level harness or CPU-visible control and the channel array; gives one aggregate done/pass with per-channel failure reporting.

---
 rtl/aes_run_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/aes_run_ctrl.sv
// aes_run_ctrl: launches AES channel engines and aggregates their done/pass results
module aes_run_ctrl #(
    parameter int NUM_CH     = 6,
    parameter int SEQUENTIAL = 0,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_CH-1:0]            ch_en,
    output logic [NUM_CH-1:0]            ch_start,
    input  logic [NUM_CH-1:0]            ch_done,
    input  logic [NUM_CH-1:0]            ch_pass,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [NUM_CH-1:0]            fail_mask,
    output logic [$clog2(NUM_CH+1)-1:0]  done_count,
    output logic [CNT_W-1:0]             cycle_count
);
    localparam int PW  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int DCW = $clog2(NUM_CH+1);
    localparam int WDW = TIMEOUT > 1 ? $clog2(TIMEOUT+1) : 1;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
    state_t state, state_d;
    logic [NUM_CH-1:0] en_q, completed_q, launched_q, remaining, new_done, comp_nxt, fail_nxt;
    logic [PW-1:0] ptr, ptr_q;
    logic [DCW-1:0] new_cnt;
    logic [WDW-1:0] wd;
    logic finish, next_launch, expire;
    // completion bookkeeping, next sequential channel and watchdog decision
    always_comb begin
        remaining = en_q & ~launched_q;
        ptr = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (remaining[i]) ptr = PW'(i);
        new_done = state == WAIT ? ch_done & en_q & ~completed_q & launched_q : '0;
        comp_nxt = completed_q | new_done;
        new_cnt = '0;
        for (int i = 0; i < NUM_CH; i++)
            new_cnt = new_cnt + DCW'(new_done[i]);
        finish = state == WAIT && comp_nxt == en_q;
        next_launch = SEQUENTIAL != 0 && state == WAIT && comp_nxt[ptr_q] && remaining != '0;
        expire = state == WAIT && !finish && !next_launch && TIMEOUT != 0 && int'(wd) + 1 == TIMEOUT;
        fail_nxt = fail_mask | (new_done & ~ch_pass) | (expire ? en_q & ~comp_nxt : '0);
        ch_start = state == LAUNCH ? (SEQUENTIAL != 0 ? NUM_CH'(1) << ptr : en_q) : '0;
        busy = state != IDLE;
    end
    // next-state logic
    always_comb begin
        state_d = state;
        if (state == IDLE)
            state_d = start && ch_en != '0 ? LAUNCH : IDLE;
        else if (state == LAUNCH)
            state_d = WAIT;
        else
            state_d = finish || expire ? IDLE : next_launch ? LAUNCH : WAIT;
    end
    // state, run context and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            en_q        <= '0;
            completed_q <= '0;
            launched_q  <= '0;
            ptr_q       <= '0;
            wd          <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_mask   <= '0;
            done_count  <= '0;
            cycle_count <= '0;
        end else begin
            state <= state_d;
            if (state != IDLE)
                cycle_count <= cycle_count + CNT_W'(!(&cycle_count));
            if (state == IDLE) begin
                if (start) begin
                    en_q        <= ch_en;
                    completed_q <= '0;
                    launched_q  <= '0;
                    done        <= ch_en == '0;
                    pass        <= ch_en == '0;
                    timeout     <= 1'b0;
                    fail_mask   <= '0;
                    done_count  <= '0;
                    cycle_count <= '0;
                end
            end else if (state == LAUNCH) begin
                launched_q <= launched_q | ch_start;
                ptr_q      <= ptr;
                wd         <= '0;
            end else begin
                completed_q <= comp_nxt;
                done_count  <= done_count + new_cnt;
                fail_mask   <= fail_nxt;
                wd          <= wd + 1'b1;
                if (finish || expire) begin
                    done    <= 1'b1;
                    pass    <= fail_nxt == '0 && !expire;
                    timeout <= expire;
                end
            end
        end
    end
endmodule
